ram_scan_ctrl: RTL and testbench
================================

RAM_SCAN_CTRL -- requirements
Module: ram_scan_ctrl

Interface
REQ-001: Parameter HOLD, default 4, sets the number of cycles each read word is presented on disp_data; legal range 1..255.
REQ-002: clock  input  1  single clock; all state updates on the rising edge.
REQ-003: resetn  input  1  reset, synchronous and active-low, sampled on the rising edge of clock.
REQ-004: start  input  1  begins an operation when sampled high in IDLE.
REQ-005: mode  input  1  sampled with start; 0 selects scan (read all words), 1 selects fill (write all words).
REQ-006: stop  input  1  aborts the current operation.
REQ-007: fill_data  input  4  base value for fill.
REQ-008: ram_q  input  4  read data from the 32x4 RAM; valid one cycle after the address edge.
REQ-009: ram_address  output  5  RAM address.
REQ-010: ram_data  output  4  RAM write data.
REQ-011: ram_wren  output  1  RAM write enable.
REQ-012: disp_addr  output  5  address of the displayed word.
REQ-013: disp_data  output  4  displayed word, fed to the hex decoder.
REQ-014: disp_valid  output  1  high while disp_data holds a freshly read word.
REQ-015: busy  output  1  high in every state except IDLE.
REQ-016: done  output  1  one-cycle pulse on normal completion.

Function
REQ-017: The FSM SHALL have the states IDLE, FILL, RD_REQ, RD_WAIT, HOLD and DONE; all outputs are registered.
REQ-018: In IDLE, start=1 with stop=0 SHALL load addr=0 and enter FILL if mode=1, or RD_REQ if mode=0.
REQ-019: Start SHALL be ignored in every state other than IDLE.
REQ-020: In FILL, each cycle SHALL drive ram_wren=1, ram_address=addr and ram_data=(fill_data+addr[3:0]) mod 16, then increment addr.
REQ-021: After the write to addr=31, FILL SHALL go to DONE; a fill is exactly 32 consecutive wren cycles.
REQ-022: RD_REQ SHALL drive ram_address=addr with ram_wren=0 for one cycle, then enter RD_WAIT.
REQ-023: RD_WAIT SHALL last one cycle; at its closing edge, disp_data<=ram_q, disp_addr<=addr, disp_valid<=1 and the hold counter loads HOLD-1, then the FSM enters HOLD.
REQ-024: HOLD SHALL keep disp_data and disp_addr stable for exactly HOLD cycles.
REQ-025: When HOLD expires and addr<31, the FSM SHALL increment addr, clear disp_valid and enter RD_REQ; when addr=31 it SHALL enter DONE.
REQ-026: Each scanned word SHALL take 2+HOLD cycles, so a full scan takes 32*(2+HOLD) cycles before DONE.
REQ-027: DONE SHALL last one cycle with done=1 and disp_valid=0, then return to IDLE; addr wraps to 0.
REQ-028: ram_wren SHALL be 1 only in FILL.
REQ-029: stop=1 in any busy state SHALL force IDLE at the next edge, with ram_wren=0, disp_valid=0 and no done pulse.
REQ-030: Writes already performed before stop SHALL stand.
REQ-031: Simultaneous start and stop in IDLE SHALL leave the FSM in IDLE; stop has priority.
REQ-032: disp_data and disp_addr SHALL keep their last value in IDLE.

Reset
REQ-033: resetn=0 at a rising edge SHALL force IDLE, addr=0, hold counter=0, ram_address=0, ram_data=0, ram_wren=0, disp_addr=0, disp_data=0, disp_valid=0, busy=0 and done=0.
REQ-034: Reset SHALL take priority over start and stop, and SHALL abort a fill or scan mid-operation with no further writes.

Verification
REQ-035: fill_data=4'hA, mode=1, start pulse -> 32 consecutive ram_wren cycles, addresses 0..31 with data A,B,..,F,0,..,9 repeating, then done for 1 cycle, busy=0.
REQ-036: After REQ-035, HOLD=4, mode=0, start -> disp_data sequence A,B,C,... with each value stable 4 cycles, done at cycle 192 after start.
REQ-037: Stop asserted during the scan at addr=7 -> IDLE next edge, no done, disp_valid=0, disp_addr stays 7.
REQ-038: resetn=0 mid-fill at addr=12 -> all outputs zero next edge, and the RAM model shows addresses 12..31 unchanged.
REQ-039: start and stop both high in IDLE -> busy stays 0; start asserted while busy -> no restart and addr progression unaffected.
REQ-040: HOLD=1 scan -> each word is displayed for exactly 1 cycle, and the total is 96 cycles to done.

Source files
------------

// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: sequences a 32x4 synchronous RAM for a fill (write every word with
//   fill_data + address) or a scan (read every word and present it for HOLD cycles).
// Latency: all outputs registered; a scanned word costs 2+HOLD cycles (request, wait, hold).
// Backpressure: none; i_stop aborts any busy state at the next edge, and i_start is ignored while busy.
//
// Ports:
//   i_clock, i_resetn  - single clock, synchronous active-low reset
//   i_start, i_mode    - start request (sampled in IDLE); mode 0 = scan, 1 = fill
//   i_stop             - abort the current operation (wins over i_start)
//   i_fill_data        - base value for a fill
//   i_ram_q            - RAM read data, valid one cycle after the address edge
//   o_ram_address, o_ram_data, o_ram_wren - RAM control
//   o_disp_addr, o_disp_data, o_disp_valid - displayed word and its address
//   o_busy, o_done     - activity flag and one-cycle completion pulse

module ram_scan_ctrl #(
  parameter int HOLD = 4  // cycles each read word is presented, 1..255
) (
  input  logic       i_clock,
  input  logic       i_resetn,
  input  logic       i_start,
  input  logic       i_mode,
  input  logic       i_stop,
  input  logic [3:0] i_fill_data,
  input  logic [3:0] i_ram_q,
  output logic [4:0] o_ram_address,
  output logic [3:0] o_ram_data,
  output logic       o_ram_wren,
  output logic [4:0] o_disp_addr,
  output logic [3:0] o_disp_data,
  output logic       o_disp_valid,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_HOLD    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [4:0] LAST_ADDR = 5'd31;
  // Counter is loaded with HOLD-1 and the hold state exits when it reads zero,
  // so the hold state occupies exactly HOLD cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

  // State and datapath registers
  state_t     r_state;
  logic [4:0] r_addr;
  logic [7:0] r_hold_cnt;

  // Registered outputs
  logic [4:0] r_ram_address;
  logic [3:0] r_ram_data;
  logic       r_ram_wren;
  logic [4:0] r_disp_addr;
  logic [3:0] r_disp_data;
  logic       r_disp_valid;
  logic       r_busy;
  logic       r_done;

  // Next-state values
  state_t     w_state_nxt;
  logic [4:0] w_addr_nxt;
  logic [7:0] w_hold_cnt_nxt;
  logic [4:0] w_ram_address_nxt;
  logic [3:0] w_ram_data_nxt;
  logic       w_ram_wren_nxt;
  logic [4:0] w_disp_addr_nxt;
  logic [3:0] w_disp_data_nxt;
  logic       w_disp_valid_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_last;

  assign w_last = (r_addr == LAST_ADDR);

  // Next-state and next-output logic. Outputs are derived from the state being
  // entered, so once registered they line up with the state they belong to.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_disp_addr_nxt = r_disp_addr;
    w_disp_data_nxt = r_disp_data;

    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_addr_nxt  = '0;
          w_state_nxt = i_mode ? S_FILL : S_RD_REQ;
        end
      end

      S_FILL: begin
        if (w_last) begin
          w_addr_nxt  = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_addr_nxt  = r_addr + 5'd1;
        end
      end

      S_RD_REQ: begin
        w_state_nxt = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        // RAM data for r_addr is on i_ram_q during this cycle.
        w_disp_data_nxt = i_ram_q;
        w_disp_addr_nxt = r_addr;
        w_hold_cnt_nxt  = HOLD_LOAD;
        w_state_nxt     = S_HOLD;
      end

      S_HOLD: begin
        if (r_hold_cnt == 8'd0) begin
          if (w_last) begin
            w_addr_nxt  = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_addr_nxt  = r_addr + 5'd1;
            w_state_nxt = S_RD_REQ;
          end
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - 8'd1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_addr_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort: return to IDLE without touching the display registers, so the
    // last shown word stays visible after a stop.
    if (i_stop && (r_state != S_IDLE)) begin
      w_state_nxt     = S_IDLE;
      w_addr_nxt      = r_addr;
      w_hold_cnt_nxt  = 8'd0;
      w_disp_addr_nxt = r_disp_addr;
      w_disp_data_nxt = r_disp_data;
    end

    // Output decode from the state being entered.
    w_ram_address_nxt = r_ram_address;
    w_ram_data_nxt    = r_ram_data;
    w_ram_wren_nxt    = (w_state_nxt == S_FILL);
    if (w_state_nxt == S_FILL) begin
      w_ram_address_nxt = w_addr_nxt;
      w_ram_data_nxt    = i_fill_data + w_addr_nxt[3:0];
    end else if (w_state_nxt == S_RD_REQ) begin
      w_ram_address_nxt = w_addr_nxt;
    end

    // A word is "fresh" exactly while the hold state is active.
    w_disp_valid_nxt = (w_state_nxt == S_HOLD);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_done_nxt       = (w_state_nxt == S_DONE);
  end

  // State and output registers
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_hold_cnt    <= '0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
      r_disp_addr   <= '0;
      r_disp_data   <= '0;
      r_disp_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_addr        <= w_addr_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_ram_address <= w_ram_address_nxt;
      r_ram_data    <= w_ram_data_nxt;
      r_ram_wren    <= w_ram_wren_nxt;
      r_disp_addr   <= w_disp_addr_nxt;
      r_disp_data   <= w_disp_data_nxt;
      r_disp_valid  <= w_disp_valid_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign o_ram_address = r_ram_address;
  assign o_ram_data    = r_ram_data;
  assign o_ram_wren    = r_ram_wren;
  assign o_disp_addr   = r_disp_addr;
  assign o_disp_data   = r_disp_data;
  assign o_disp_valid  = r_disp_valid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// tb_ram_scan_ctrl: drives two controllers (HOLD=4 and HOLD=1), each attached to a
//   behavioural 32x4 synchronous RAM, and checks fills, scans, stop and reset behaviour
//   against expected RAM contents computed arithmetically in the bench.

module tb_ram_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       start [2];
  logic       stop  [2];
  logic       mode  [2];
  logic [3:0] fill  [2];
  logic [3:0] ram_q [2];

  logic [4:0] ram_addr_0, ram_addr_1, disp_addr_0, disp_addr_1;
  logic [3:0] ram_data_0, ram_data_1, disp_data_0, disp_data_1;
  logic       ram_wren_0, ram_wren_1, disp_valid_0, disp_valid_1;
  logic       busy_0, busy_1, done_0, done_1;

  logic [4:0] ram_addr   [2];
  logic [3:0] ram_data   [2];
  logic       ram_wren   [2];
  logic [4:0] disp_addr  [2];
  logic [3:0] disp_data  [2];
  logic       disp_valid [2];
  logic       busy       [2];
  logic       done       [2];

  logic [3:0] mem [2][32];
  int         exp_mem [2][32];

  int tests = 0;
  int fails = 0;

  ram_scan_ctrl #(.HOLD(4)) u_dut4 (
    .i_clock(clk), .i_resetn(resetn), .i_start(start[0]), .i_mode(mode[0]),
    .i_stop(stop[0]), .i_fill_data(fill[0]), .i_ram_q(ram_q[0]),
    .o_ram_address(ram_addr_0), .o_ram_data(ram_data_0), .o_ram_wren(ram_wren_0),
    .o_disp_addr(disp_addr_0), .o_disp_data(disp_data_0), .o_disp_valid(disp_valid_0),
    .o_busy(busy_0), .o_done(done_0)
  );

  ram_scan_ctrl #(.HOLD(1)) u_dut1 (
    .i_clock(clk), .i_resetn(resetn), .i_start(start[1]), .i_mode(mode[1]),
    .i_stop(stop[1]), .i_fill_data(fill[1]), .i_ram_q(ram_q[1]),
    .o_ram_address(ram_addr_1), .o_ram_data(ram_data_1), .o_ram_wren(ram_wren_1),
    .o_disp_addr(disp_addr_1), .o_disp_data(disp_data_1), .o_disp_valid(disp_valid_1),
    .o_busy(busy_1), .o_done(done_1)
  );

  always_comb begin
    ram_addr[0] = ram_addr_0;   ram_addr[1] = ram_addr_1;
    ram_data[0] = ram_data_0;   ram_data[1] = ram_data_1;
    ram_wren[0] = ram_wren_0;   ram_wren[1] = ram_wren_1;
    disp_addr[0] = disp_addr_0; disp_addr[1] = disp_addr_1;
    disp_data[0] = disp_data_0; disp_data[1] = disp_data_1;
    disp_valid[0] = disp_valid_0; disp_valid[1] = disp_valid_1;
    busy[0] = busy_0;           busy[1] = busy_1;
    done[0] = done_0;           done[1] = done_1;
  end

  // Synchronous RAMs: read data appears one cycle after the address edge.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ram_q[k] <= mem[k][ram_addr[k]];
      if (ram_wren[k]) mem[k][ram_addr[k]] <= ram_data[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_ram_addr"}, ram_addr[k], 0);
    chk({tag, "_ram_data"}, ram_data[k], 0);
    chk({tag, "_ram_wren"}, ram_wren[k], 0);
    chk({tag, "_disp_addr"}, disp_addr[k], 0);
    chk({tag, "_disp_data"}, disp_data[k], 0);
    chk({tag, "_disp_valid"}, disp_valid[k], 0);
    chk({tag, "_busy"}, busy[k], 0);
    chk({tag, "_done"}, done[k], 0);
  endtask

  task automatic chk_mem(input int k, input string tag);
    for (int i = 0; i < 32; i++) chk(tag, mem[k][i], exp_mem[k][i]);
  endtask

  // Fill: expect 32 back-to-back writes of (base + address) mod 16, then one done cycle.
  task automatic do_fill(input int k, input logic [3:0] fv);
    @(negedge clk);
    fill[k] = fv; mode[k] = 1'b1; start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    for (int n = 0; n < 32; n++) begin
      chk("fill_wren", ram_wren[k], 1);
      chk("fill_addr", ram_addr[k], n);
      chk("fill_data", ram_data[k], (int'(fv) + n) % 16);
      exp_mem[k][n] = (int'(fv) + n) % 16;
      @(negedge clk);
    end
    chk("fill_done", done[k], 1);
    chk("fill_done_wren", ram_wren[k], 0);
    @(negedge clk);
    chk("fill_done_pulse", done[k], 0);
    chk("fill_idle_busy", busy[k], 0);
    chk_mem(k, "fill_mem");
  endtask

  // Scan: every word must appear once, in address order, valid for exactly `hold`
  // cycles, and the busy span before done must be 32*(2+hold). A start pulse is
  // injected mid-scan at sample `inj` (if >= 0) and must have no effect.
  task automatic do_scan(input int k, input int hold, input int inj);
    int w, run, busy_cnt, wren_cnt, unstable;
    logic [4:0] ra;
    logic [3:0] rd;
    bit got_done;
    w = 0; run = 0; busy_cnt = 0; wren_cnt = 0; unstable = 0; got_done = 0;
    ra = '0; rd = '0;
    @(negedge clk);
    mode[k] = 1'b0; start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    for (int n = 0; n < 32 * (2 + hold) + 16; n++) begin
      if (n == inj) begin start[k] = 1'b1; mode[k] = 1'b1; end
      else begin start[k] = 1'b0; mode[k] = 1'b0; end
      if (disp_valid[k]) begin
        if (run == 0) begin ra = disp_addr[k]; rd = disp_data[k]; end
        else if (disp_addr[k] !== ra || disp_data[k] !== rd) unstable++;
        run++;
      end else if (run > 0) begin
        if (w < 32) begin
          chk("scan_addr", ra, w);
          chk("scan_data", rd, exp_mem[k][w]);
          chk("scan_hold", run, hold);
        end
        w++; run = 0;
      end
      if (done[k]) begin got_done = 1; break; end
      busy_cnt += int'(busy[k]);
      wren_cnt += int'(ram_wren[k]);
      @(negedge clk);
    end
    start[k] = 1'b0; mode[k] = 1'b0;
    chk("scan_done_seen", got_done, 1);
    chk("scan_words", w, 32);
    chk("scan_cycles", busy_cnt, 32 * (2 + hold));
    chk("scan_no_wren", wren_cnt, 0);
    chk("scan_stable", unstable, 0);
    chk("scan_done_valid", disp_valid[0 + k], 0);
    @(negedge clk);
    chk("scan_done_pulse", done[k], 0);
    chk("scan_idle_busy", busy[k], 0);
  endtask

  initial begin
    logic [3:0] fv1, fv2;
    int found, extra, done_cnt;

    for (int k = 0; k < 2; k++) begin
      start[k] = 0; stop[k] = 0; mode[k] = 0; fill[k] = 0;
    end
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero(0, "rst4");
    chk_zero(1, "rst1");
    resetn = 1'b1;

    // Fill with A, then scan with a spurious start injected mid-scan.
    do_fill(0, 4'hA);
    do_scan(0, 4, int'($urandom_range(10, 150)));

    // Start and stop together in IDLE: stop wins.
    @(negedge clk);
    start[0] = 1'b1; stop[0] = 1'b1; mode[0] = 1'b0;
    @(negedge clk);
    chk("ss_busy", busy[0], 0);
    start[0] = 1'b0; stop[0] = 1'b0;
    @(negedge clk);
    chk("ss_busy2", busy[0], 0);
    chk("ss_wren", ram_wren[0], 0);
    // Display keeps the last scanned word while idle.
    chk("idle_disp_addr", disp_addr[0], 31);
    chk("idle_disp_data", disp_data[0], exp_mem[0][31]);

    // Stop during the scan while word 7 is displayed.
    @(negedge clk);
    mode[0] = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      if (disp_valid[0] && disp_addr[0] == 5'd7) begin found = 1; break; end
      @(negedge clk);
    end
    chk("stop_reach7", found, 1);
    extra = int'($urandom_range(0, 2));
    repeat (extra) @(negedge clk);
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    chk("stop_busy", busy[0], 0);
    chk("stop_done", done[0], 0);
    chk("stop_valid", disp_valid[0], 0);
    chk("stop_wren", ram_wren[0], 0);
    chk("stop_disp_addr", disp_addr[0], 7);
    chk("stop_disp_data", disp_data[0], exp_mem[0][7]);
    done_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      done_cnt += int'(done[0]);
    end
    chk("stop_no_done", done_cnt, 0);
    chk("stop_disp_hold", disp_addr[0], 7);

    // Reset during a fill once addresses 0..11 are written: later words keep old data.
    fv1 = 4'($urandom_range(0, 15));
    do_fill(0, fv1);
    fv2 = fv1 + 4'($urandom_range(1, 15));
    @(negedge clk);
    fill[0] = fv2; mode[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (11) @(negedge clk);
    chk("rfill_addr11", ram_addr[0], 11);
    resetn = 1'b0;
    start[0] = 1'b1;  // reset must dominate a concurrent start
    @(negedge clk);
    for (int i = 0; i < 12; i++) exp_mem[0][i] = (int'(fv2) + i) % 16;
    chk_zero(0, "rfill");
    start[0] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rfill_after_wren", ram_wren[0], 0);
    chk("rfill_after_busy", busy[0], 0);
    chk_mem(0, "rfill_mem");

    // HOLD=1 controller: random fill then a fast scan.
    do_fill(1, 4'($urandom_range(0, 15)));
    do_scan(1, 1, -1);

    // One more randomized round on the HOLD=4 controller.
    do_fill(0, 4'($urandom_range(0, 15)));
    do_scan(0, 4, int'($urandom_range(0, 190)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
